// File: rtl/req_ack_pkg.sv
// req_ack_pkg: state encoding shared by the responder and the arbiter-side bench
package req_ack_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      ACK     = 2'd2,
      RECOVER = 2'd3
   } state_t;
endpackage

// File: rtl/req_ack_responder_sat_counter.sv
// sat_counter: event counter that sticks at its all-ones maximum
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk)
      count <= !rstn ? '0 : (inc && count != '1) ? count + CNT_W'(1) : count;
endmodule

// File: rtl/req_ack_responder.sv
// req_ack_responder: fixed-latency shared resource returning a one-cycle ack pulse
module req_ack_responder
   import req_ack_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int GAP     = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_i,
   input  logic             en,
   output logic             ack_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic [CNT_W-1:0] abort_cnt_o
);
   localparam int MAXV = LATENCY > GAP ? LATENCY : GAP;
   localparam int WW   = $clog2(MAXV + 1) < 1 ? 1 : $clog2(MAXV + 1);
   state_t        state;
   logic [WW-1:0] wait_cnt;
   always_ff @(posedge clk)
      if (!rstn) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else
         case (state)
            IDLE:
               if (req_i && en) begin
                  if (LATENCY == 1)
                     state <= ACK;
                  else begin
                     state    <= WAIT;
                     wait_cnt <= WW'(LATENCY - 2);
                  end
               end
            WAIT:
               if (!req_i)
                  state <= IDLE;
               else if (en) begin
                  if (wait_cnt == '0)
                     state <= ACK;
                  else
                     wait_cnt <= wait_cnt - WW'(1);
               end
            ACK:
               if (GAP > 0) begin
                  state    <= RECOVER;
                  wait_cnt <= WW'(GAP - 1);
               end else
                  state <= IDLE;
            RECOVER:
               if (wait_cnt == '0)
                  state <= IDLE;
               else
                  wait_cnt <= wait_cnt - WW'(1);
            default: state <= IDLE;
         endcase
   assign ack_o  = state == ACK;
   assign busy_o = state != IDLE;
   // a dropped request counts as an abort whether it happens in WAIT or in the ACK cycle
   sat_counter #(.CNT_W(CNT_W)) u_done (
      .clk  (clk),
      .rstn (rstn),
      .inc  (ack_o && req_i),
      .count(done_cnt_o)
   );
   sat_counter #(.CNT_W(CNT_W)) u_abort (
      .clk  (clk),
      .rstn (rstn),
      .inc  (!req_i && (state == WAIT || state == ACK)),
      .count(abort_cnt_o)
   );
endmodule

// File: tb/tb_req_ack_responder.sv
// tb_req_ack_responder: directed checks of latency, gap, aborts, reset and saturation
module tb_req_ack_responder;
   logic clk = 1'b0;
   logic rstn, req, en;
   logic       ack1, busy1, ack2, busy2, ack3, busy3;
   logic [7:0] done1, abort1, done3, abort3;
   logic [3:0] done2, abort2;
   logic [2:0] reqs, arb;
   int n_run = 0, n_fail = 0;
   always #5 clk = ~clk;
   req_ack_responder #(.LATENCY(2), .GAP(1), .CNT_W(8)) d1 (
      .clk(clk), .rstn(rstn), .req_i(req), .en(en), .ack_o(ack1), .busy_o(busy1),
      .done_cnt_o(done1), .abort_cnt_o(abort1));
   req_ack_responder #(.LATENCY(2), .GAP(1), .CNT_W(4)) d2 (
      .clk(clk), .rstn(rstn), .req_i(req), .en(en), .ack_o(ack2), .busy_o(busy2),
      .done_cnt_o(done2), .abort_cnt_o(abort2));
   req_ack_responder #(.LATENCY(1), .GAP(0), .CNT_W(8)) d3 (
      .clk(clk), .rstn(rstn), .req_i(req), .en(en), .ack_o(ack3), .busy_o(busy3),
      .done_cnt_o(done3), .abort_cnt_o(abort3));
   // arbiter model: ack goes to the lowest-index active requester
   assign arb = ack1 ? (reqs & (~reqs + 3'd1)) : 3'd0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rstn = 1'b0; req = 1'b0; en = 1'b1; reqs = 3'b000;
      tick; tick;
      rstn = 1'b1;
   endtask
   initial begin
      do_reset;
      chk("rst_ack", {31'd0, ack1}, 0);
      chk("rst_busy", {31'd0, busy1}, 0);
      chk("rst_done", {24'd0, done1}, 0);
      chk("rst_abort", {24'd0, abort1}, 0);
      req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("held_ack c%0d", k), {31'd0, ack1}, (k == 2 || k == 6 || k == 10) ? 1 : 0);
         chk($sformatf("held_busy c%0d", k), {31'd0, busy1}, (k % 4 == 0) ? 0 : 1);
         chk($sformatf("l1g0_ack c%0d", k), {31'd0, ack3}, k % 2);
         if (k == 3 || k == 7 || k == 11)
            chk($sformatf("held_done c%0d", k), {24'd0, done1}, (k + 1) / 4);
         tick;
      end
      do_reset;
      req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("abort_ack c%0d", k), {31'd0, ack1}, 0);
         if (k == 1) chk("abort_busy_wait", {31'd0, busy1}, 1);
         if (k == 1) chk("l1g0_ack_nogrant", {31'd0, ack3}, 1);
         if (k == 2) chk("abort_busy_idle", {31'd0, busy1}, 0);
         if (k == 1) chk("abort_cnt_pre", {24'd0, abort1}, 0);
         if (k >= 2) chk($sformatf("abort_cnt c%0d", k), {24'd0, abort1}, 1);
         if (k == 2) chk("l1g0_abort", {24'd0, abort3}, 1);
         if (k == 2) chk("abort_done", {24'd0, done1}, 0);
         tick;
         req = 1'b0;
      end
      do_reset;
      req = 1'b1;
      for (int k = 0; k < 7; k++) begin
         en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
         chk($sformatf("en_ack c%0d", k), {31'd0, ack1}, (k == 5) ? 1 : 0);
         if (k >= 5) chk($sformatf("en_done c%0d", k), {24'd0, done1}, (k == 6) ? 1 : 0);
         tick;
      end
      do_reset;
      req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rstn = (k == 1) ? 1'b0 : 1'b1;
         if (k == 2) begin
            chk("midrst_busy", {31'd0, busy1}, 0);
            chk("midrst_ack", {31'd0, ack1}, 0);
            chk("midrst_done", {24'd0, done1}, 0);
            chk("midrst_abort", {24'd0, abort1}, 0);
         end
         if (k >= 2) chk($sformatf("midrst_ack c%0d", k), {31'd0, ack1}, (k == 4) ? 1 : 0);
         tick;
      end
      do_reset;
      req = 1'b1;
      for (int k = 0; k <= 90; k++) begin
         if (k == 55) chk("sat_done c55", {28'd0, done2}, 14);
         if (k == 59) chk("sat_done c59", {28'd0, done2}, 15);
         if (k == 90) begin
            chk("sat_done c90", {28'd0, done2}, 15);
            chk("sat_abort", {28'd0, abort2}, 0);
            chk("wide_done c90", {24'd0, done1}, 22);
         end
         tick;
      end
      do_reset;
      reqs = 3'b101;
      req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k == 7) reqs = 3'b100;
         chk($sformatf("arb_ack c%0d", k), {29'd0, arb},
             (k == 2 || k == 6) ? 3'b001 : (k == 10) ? 3'b100 : 3'b000);
         tick;
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
